// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register-address width, forwarding select codes
// and the per-stage instruction tag used by the hazard/forwarding logic.
package pipe_pkg;

    localparam int REG_AW = 5;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } tag_t;

    localparam tag_t BUBBLE_TAG = '0;

    // A stage can supply a forwarded value for src only if it really writes a non-zero rd.
    function automatic logic tag_produces(input tag_t t, input logic [REG_AW-1:0] src);
        return t.valid && t.reg_write && (t.rd != {REG_AW{1'b0}}) && (t.rd == src);
    endfunction

endpackage

// File: rtl/fwd_sel_gen.sv
// Forwarding select for one EX operand: picks the youngest in-flight producer
// of the source register, MEM ahead of WB, falling back to the register file.
module fwd_sel_gen
    import pipe_pkg::*;
(
    input  logic [REG_AW-1:0] src,
    input  tag_t              mem_tag,
    input  tag_t              wb_tag,
    output logic [1:0]        sel
);

    logic unused_tag_bits_s;

    // Source-register fields and load flag of the older stages play no part in forwarding.
    assign unused_tag_bits_s = ^{mem_tag.rs1, mem_tag.rs2, mem_tag.mem_read,
                                 wb_tag.rs1, wb_tag.rs2, wb_tag.mem_read};

    // Priority select: MEM result is more recent than WB result.
    always_comb begin
        sel = SEL_RF;
        if (tag_produces(mem_tag, src)) begin
            sel = SEL_MEM;
        end else if (tag_produces(wb_tag, src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Load-use hazard detection and EX-operand forwarding for a 5-stage pipeline,
// tracking EX/MEM/WB instruction tags and counting stall cycles.
module hazard_forward_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_count
);

    import pipe_pkg::*;

    tag_t             ex_q, ex_d;
    tag_t             mem_q, mem_d;
    tag_t             wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stall_s;
    logic             insert_bubble_s;

    // Load in EX whose result the ID instruction needs; a flush makes the wait pointless.
    always_comb begin
        stall_s = 1'b0;
        if (id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != {REG_AW{1'b0}}) &&
            ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && !flush) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end
    end

    assign insert_bubble_s = stall_s | flush;

    // Next tag pipeline and saturating stall counter.
    always_comb begin
        ex_d  = BUBBLE_TAG;
        mem_d = ex_q;
        wb_d  = mem_q;
        cnt_d = cnt_q;
        if (insert_bubble_s) begin
            ex_d = BUBBLE_TAG;
        end else begin
            ex_d.valid     = id_valid;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
        if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= BUBBLE_TAG;
            mem_q <= BUBBLE_TAG;
            wb_q  <= BUBBLE_TAG;
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    fwd_sel_gen u_fwd_a (
        .src     (ex_q.rs1),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_a_sel)
    );

    fwd_sel_gen u_fwd_b (
        .src     (ex_q.rs2),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (fwd_b_sel)
    );

    assign stall       = stall_s;
    assign bubble      = insert_bubble_s;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed hazard scenarios plus random traffic against a
// behavioural in-flight instruction model; a 4-bit-counter copy checks saturation.
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_reg_write, id_mem_read, flush;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  a16, b16, a4, b4;
    logic        stall16, bubble16, stall4, bubble4;
    logic [15:0] cnt16;
    logic [3:0]  cnt4;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit wr;
        bit mr;
    } ins_t;

    ins_t pipe[3];    // 0 = oldest-but-one... index 0 = EX, 1 = MEM, 2 = WB
    int   m_cnt16;
    int   m_cnt4;

    always #5 clk = ~clk;

    hazard_forward_unit #(.REG_AW(5), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(a16), .fwd_b_sel(b16), .stall(stall16), .bubble(bubble16), .stall_count(cnt16)
    );

    hazard_forward_unit #(.REG_AW(5), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
        .fwd_a_sel(a4), .fwd_b_sel(b4), .stall(stall4), .bubble(bubble4), .stall_count(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0, 0};
        m_cnt16 = 0;
        m_cnt4  = 0;
    endtask

    // Youngest older instruction that writes src (never x0) supplies the operand.
    function automatic int exp_sel(input int src);
        if (pipe[1].v && pipe[1].wr && pipe[1].rd != 0 && pipe[1].rd == src) return 2;
        if (pipe[2].v && pipe[2].wr && pipe[2].rd != 0 && pipe[2].rd == src) return 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        return id_valid && !flush && pipe[0].v && pipe[0].mr && pipe[0].rd != 0 &&
               (pipe[0].rd == int'(id_rs1) || pipe[0].rd == int'(id_rs2));
    endfunction

    task automatic check_model();
        bit st;
        st = exp_stall();
        chk("fwd_a",   32'(a16),      32'(exp_sel(pipe[0].rs1)));
        chk("fwd_b",   32'(b16),      32'(exp_sel(pipe[0].rs2)));
        chk("stall",   32'(stall16),  32'(st));
        chk("bubble",  32'(bubble16), 32'(st | flush));
        chk("cnt16",   32'(cnt16),    32'(m_cnt16));
        chk("fwd_a4",  32'(a4),       32'(exp_sel(pipe[0].rs1)));
        chk("fwd_b4",  32'(b4),       32'(exp_sel(pipe[0].rs2)));
        chk("stall4",  32'(stall4),   32'(st));
        chk("bubble4", 32'(bubble4),  32'(st | flush));
        chk("cnt4",    32'(cnt4),     32'(m_cnt4));
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit wr, input bit mr, input bit fl);
        id_valid     = v;
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_rd        = 5'(rd);
        id_reg_write = wr;
        id_mem_read  = mr;
        flush        = fl;
        #1;
        check_model();
    endtask

    task automatic tick();
        bit st;
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            st = exp_stall();
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            if (st || flush) pipe[0] = '{0, 0, 0, 0, 0, 0};
            else pipe[0] = '{id_valid, int'(id_rs1), int'(id_rs2), int'(id_rd),
                             id_reg_write, id_mem_read};
            if (st) begin
                if (m_cnt16 < 65535) m_cnt16++;
                if (m_cnt4 < 15) m_cnt4++;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int saved;
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);

        // Reset state: no forwarding, no stall, bubble follows flush.
        drive(1, 1, 2, 3, 1, 1, 1);
        chk("rst_bubble_flush", 32'(bubble16), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rst_cnt", 32'(cnt16), 32'd0);
        tick();
        rst_n = 1'b1;

        // add x5 then sub x6,x5,x1 -> MEM forward; one slot later -> WB forward.
        drive(1, 0, 0, 5, 1, 0, 0); tick();
        drive(1, 5, 1, 6, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("addsub_mem_fwd", 32'(a16), 32'd2);
        tick();
        drive(1, 0, 0, 5, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 5, 0, 8, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("addsub_wb_fwd", 32'(a16), 32'd1);
        tick();

        // Two producers of x7 in MEM and WB; consumer on rs2 takes MEM.
        drive(1, 0, 0, 7, 1, 0, 0); tick();
        drive(1, 0, 0, 7, 1, 0, 0); tick();
        drive(1, 0, 7, 9, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("x7_mem_priority", 32'(b16), 32'd2);
        tick();

        // lw x3 ; add x4,x3,x1 -> exactly one stall cycle, then WB forward.
        drive(1, 0, 0, 3, 1, 1, 0); tick();
        drive(1, 3, 1, 4, 1, 0, 0);
        chk("lu_stall", 32'(stall16), 32'd1);
        chk("lu_bubble", 32'(bubble16), 32'd1);
        tick();
        drive(1, 3, 1, 4, 1, 0, 0);
        chk("lu_stall_once", 32'(stall16), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_wb_fwd", 32'(a16), 32'd1);
        chk("lu_cnt", 32'(cnt16), 32'd1);
        tick();

        // Load writing x0 followed by a reader of x0: no stall, no forward.
        drive(1, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 2, 1, 0, 0);
        chk("x0_no_stall", 32'(stall16), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("x0_fwd_a", 32'(a16), 32'd0);
        chk("x0_fwd_b", 32'(b16), 32'd0);
        tick();

        // Load-use coinciding with flush: flush wins, counter untouched.
        drive(1, 0, 0, 3, 1, 1, 0); tick();
        saved = m_cnt16;
        drive(1, 3, 1, 4, 1, 0, 1);
        chk("flush_no_stall", 32'(stall16), 32'd0);
        chk("flush_bubble", 32'(bubble16), 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("flush_cnt", 32'(cnt16), 32'(saved));
        tick();

        // Twenty further load-use stalls: 4-bit counter saturates.
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 0, 3, 1, 1, 0); tick();
            drive(1, 3, 0, 4, 1, 0, 0); tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt4", 32'(cnt4), 32'd15);
        chk("cnt16_21", 32'(cnt16), 32'd21);
        tick();

        // Random traffic over a small register set to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) != 0), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 7) == 0));
            tick();
        end

        // Asynchronous reset mid-stream: outputs drop immediately, tags discarded.
        drive(1, 0, 0, 2, 1, 1, 0); tick();
        drive(1, 2, 2, 1, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_stall", 32'(stall16), 32'd0);
        chk("arst_bubble", 32'(bubble16), 32'd1);
        chk("arst_cnt", 32'(cnt16), 32'd0);
        chk("arst_cnt4", 32'(cnt4), 32'd0);
        chk("arst_fwd_a", 32'(a16), 32'd0);
        check_model();
        tick();
        rst_n = 1'b1;
        drive(1, 2, 1, 5, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_fwd_a", 32'(a16), 32'd0);
        chk("post_rst_fwd_b", 32'(b16), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have port id_rs1, id_rs2  input  REG_AW each  ID source registers.
REQ-007 SHALL have port id_rd  input  REG_AW  ID destination register.
REQ-008 SHALL have port id_reg_write  input  1  ID instruction writes rd.
REQ-009 SHALL have port id_mem_read  input  1  ID instruction is a load.
REQ-010 SHALL have port flush  input  1  branch-taken squash of the ID instruction.
REQ-011 SHALL have port fwd_a_sel, fwd_b_sel  output  2 each  select for the EX operand A/B 3-to-1 muxes.
REQ-012 SHALL have port stall  output  1  hold PC and IF/ID register.
REQ-013 SHALL have port bubble  output  1  ID/EX register loads a NOP this cycle.
REQ-014 SHALL have port stall_count  output  CNT_W  saturating count of stall cycles.

Function
REQ-015 SHALL keep three internal tag stages EX, MEM, WB, each {valid, rs1, rs2, rd, reg_write, mem_read}.
REQ-016 SHALL, each edge: WB<-MEM, MEM<-EX, EX<-ID inputs, unless stall or flush, in which case EX<-bubble tag (all fields zero).
REQ-017 SHALL give flush priority over stall; both asserted -> EX gets a bubble, stall_count not incremented.
REQ-018 SHALL encode select values as 00 = register file, 01 = WB result, 10 = MEM result; 11 never driven.
REQ-019 SHALL drive fwd_a_sel = 10 when MEM.valid & MEM.reg_write & MEM.rd != 0 & MEM.rd == EX.rs1; else 01 when the same condition holds for WB; else 00.
REQ-020 SHALL compute fwd_b_sel identically, using EX.rs2.
REQ-021 SHALL give MEM priority over WB when both match (most recent producer wins).
REQ-022 SHALL never forward register 0, even when reg_write is set and rd == 0.
REQ-023 SHALL assert stall combinationally (same cycle) when id_valid & EX.valid & EX.mem_read & EX.rd != 0 & (EX.rd == id_rs1 | EX.rd == id_rs2) & ~flush.
REQ-024 SHALL assert bubble = stall | flush.
REQ-025 SHALL make a load-use hazard last exactly one stall cycle; the next cycle resolves via fwd_*_sel = 01 from WB.
REQ-026 SHALL derive fwd_*_sel from registered tags only (no combinational path from id_* inputs).
REQ-027 SHALL increment stall_count on each edge where stall = 1, saturating at all-ones without wrap.

Reset
REQ-028 SHALL, while rst_n = 0, clear all tag stages to bubble and stall_count to 0, asynchronously.
REQ-029 SHALL therefore drive fwd_a_sel = fwd_b_sel = 00, stall = 0, bubble = flush while reset is active.
REQ-030 SHALL discard all tags on reset mid-operation; no forwarding from pre-reset instructions.

Structure
REQ-031 SHALL take the tag struct, REG_AW, and the SEL_RF/SEL_WB/SEL_MEM constants from a shared package, pipe_pkg.
REQ-032 SHALL instantiate one sub-module, fwd_sel_gen (one per operand), mapping {src reg, MEM tag, WB tag} to a 2-bit select.

Verification
REQ-033 SHALL cover: add x5 in EX then sub using x5 as rs1 -> next cycle fwd_a_sel = 10, then 01 if consumed one slot later.
REQ-034 SHALL cover: MEM and WB both write x7, EX reads x7 on rs2 -> fwd_b_sel = 10.
REQ-035 SHALL cover: lw x3 followed by add x4,x3,x1 -> stall = 1 and bubble = 1 for exactly one cycle, then fwd_a_sel = 01.
REQ-036 SHALL cover: instruction writes x0, consumer reads x0 -> fwd_*_sel = 00 and stall = 0.
REQ-037 SHALL cover: load-use plus flush in the same cycle -> stall = 0, bubble = 1, stall_count unchanged.
REQ-038 SHALL cover: CNT_W = 4 with 20 stalls -> stall_count = 15, then rst_n low mid-stream -> all outputs at reset values immediately.
